// File: rtl/fifo_write_arbiter_if.sv
// Producer-side and FIFO-side signals of the shared FIFO write port.
// master is the arbiter; slave is whatever drives producers/consumer and watches status.
interface fifo_write_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_write;
    logic [DATA_W-1:0]       fifo_data;
    logic                    fifo_clear;
    logic                    fifo_read;
    logic                    flush;
    logic [OW-1:0]           grant_id;
    logic [LW-1:0]           level;
    logic                    busy;

    modport master (
        input  req_valid, req_data, fifo_read, flush,
        output req_ready, fifo_write, fifo_data, fifo_clear, grant_id, level, busy
    );

    modport slave (
        output req_valid, req_data, fifo_read, flush,
        input  req_ready, fifo_write, fifo_data, fifo_clear, grant_id, level, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-limited arbiter for one FIFO write port, with its own
// occupancy tracking so the FIFO is never overfilled, and flush sequencing.
//
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin (1-cycle latency)
//   BURST | owner may write up to MAX_BURST beats while space remains
//   FLUSH | one-cycle fifo_clear pulse, level forced to 0
module fifo_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 8,
    parameter int MAX_BURST = 4
) (
    input logic clock,
    input logic reset,
    fifo_write_arbiter_if.master bus
);
    localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, FLUSH = 2'd2} state_t;

    state_t        state, state_nx;
    logic [OW-1:0] owner, owner_nx;
    logic [OW-1:0] last_owner, last_owner_nx;
    logic [OW-1:0] pick;
    logic          pick_ok;
    logic [BW-1:0] beat_cnt, beat_cnt_nx;
    logic [LW-1:0] level, level_nx;
    logic          space;
    logic          xfer;
    logic          rd_ok;
    logic          owner_valid;
    logic [DATA_W-1:0] owner_data;

    // Space is judged on registered level only; a read this cycle frees room next cycle.
    assign space = (level < LW'(DEPTH));
    assign owner_valid = bus.req_valid[owner];

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner == OW'(i)) owner_data = bus.req_data[i*DATA_W +: DATA_W];
        end
    end

    // Scan downwards so the nearest requester after last_owner is written last and wins.
    always_comb begin
        logic [OW-1:0] cand;
        cand    = '0;
        pick    = '0;
        pick_ok = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = OW'((int'(last_owner) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                pick    = cand;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_owner_nx  = last_owner;
        beat_cnt_nx    = beat_cnt;
        xfer           = 1'b0;
        bus.req_ready  = '0;
        bus.fifo_write = 1'b0;
        bus.fifo_data  = '0;
        bus.fifo_clear = 1'b0;
        case (state)
            IDLE: begin
                if (bus.flush) begin
                    state_nx = FLUSH;
                end else if (pick_ok && space) begin
                    owner_nx    = pick;
                    beat_cnt_nx = '0;
                    state_nx    = BURST;
                end
            end
            BURST: begin
                bus.req_ready[owner] = ~bus.flush & space;
                xfer = owner_valid & ~bus.flush & space;
                if (xfer) begin
                    bus.fifo_write = 1'b1;
                    bus.fifo_data  = owner_data;
                    beat_cnt_nx    = beat_cnt + 1'b1;
                end
                if (bus.flush) begin
                    state_nx      = FLUSH;
                    last_owner_nx = owner;
                end else if (!owner_valid || (xfer && beat_cnt_nx == BW'(MAX_BURST))) begin
                    state_nx      = IDLE;
                    last_owner_nx = owner;
                end
            end
            FLUSH: begin
                bus.fifo_clear = 1'b1;
                state_nx       = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rd_ok    = bus.fifo_read & (level != '0);
    assign level_nx = (state == FLUSH) ? '0 : level + LW'(xfer) - LW'(rd_ok);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(N_REQ - 1);
            beat_cnt   <= '0;
            level      <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_owner_nx;
            beat_cnt   <= beat_cnt_nx;
            level      <= level_nx;
        end
    end

    assign bus.grant_id = owner;
    assign bus.level    = level;
    assign bus.busy     = (state == BURST);
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed bench for fifo_write_arbiter: inputs change at the falling edge and
// outputs are sampled 1 time unit later, mid-cycle.
module tb_fifo_write_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    fifo_write_arbiter_if #(.N_REQ(4), .DATA_W(16), .DEPTH(8)) bus ();

    fifo_write_arbiter #(.N_REQ(4), .DATA_W(16), .DEPTH(8), .MAX_BURST(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic clear_inputs();
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_read = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clock);
        #1;
        checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", bus.level); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", bus.grant_id); end
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", bus.req_ready); end
        checks++; if (bus.fifo_write !== 1'b0 || bus.fifo_clear !== 1'b0) begin errors++; $display("FAIL reset_strobes got w=%b c=%b exp 0 0", bus.fifo_write, bus.fifo_clear); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single_burst();
        logic [15:0] exp_d;
        bus.req_valid = 4'b0001;
        bus.req_data[15:0] = 16'hA000;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.fifo_write !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b w=%b exp 0 0", bus.busy, bus.fifo_write); end
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            exp_d = 16'hA000 + 16'(b);
            bus.req_data[15:0] = exp_d;
            #1;
            checks++; if (bus.busy !== 1'b1 || bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready beat %0d got busy=%b rdy=%b exp 1 0001", b, bus.busy, bus.req_ready); end
            checks++; if (bus.fifo_write !== 1'b1 || bus.fifo_data !== exp_d) begin errors++; $display("FAIL single_write beat %0d got w=%b d=%h exp 1 %h", b, bus.fifo_write, bus.fifo_data, exp_d); end
            checks++; if (bus.level !== 4'(b)) begin errors++; $display("FAIL single_level beat %0d got %0d exp %0d", b, bus.level, b); end
        end
        // After 4 beats the grant ends; last_owner=0, so with 0 and 1 valid, 1 wins next.
        @(negedge clock);
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.level !== 4'd4 || bus.fifo_write !== 1'b0) begin errors++; $display("FAIL single_end got busy=%b lvl=%0d w=%b exp 0 4 0", bus.busy, bus.level, bus.fifo_write); end
        @(negedge clock);
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd1) begin errors++; $display("FAIL single_next_owner got busy=%b id=%0d exp 1 1", bus.busy, bus.grant_id); end
        @(negedge clock);
    endtask

    task automatic test_full_stall();
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) bus.req_data[i*16 +: 16] = 16'hB000 + 16'(i);
        #1;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL stall_first_idle got busy=%b exp 0", bus.busy); end
        for (int g = 0; g < 2; g++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clock); #1;
                checks++; if (bus.grant_id !== 2'(g) || bus.fifo_write !== 1'b1 || bus.fifo_data !== 16'hB000 + 16'(g)) begin errors++; $display("FAIL stall_beat g%0d b%0d got id=%0d w=%b d=%h exp %0d 1 %h", g, b, bus.grant_id, bus.fifo_write, bus.fifo_data, g, 16'hB000 + 16'(g)); end
                checks++; if (bus.level !== 4'(g*4 + b)) begin errors++; $display("FAIL stall_level g%0d b%0d got %0d exp %0d", g, b, bus.level, g*4 + b); end
            end
            @(negedge clock); #1;
            checks++; if (bus.busy !== 1'b0 || bus.level !== 4'((g+1)*4)) begin errors++; $display("FAIL stall_gap g%0d got busy=%b lvl=%0d exp 0 %0d", g, bus.busy, bus.level, (g+1)*4); end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clock); #1;
            checks++; if (bus.req_ready !== 4'b0000 || bus.busy !== 1'b0 || bus.level !== 4'd8) begin errors++; $display("FAIL stall_full got rdy=%b busy=%b lvl=%0d exp 0000 0 8", bus.req_ready, bus.busy, bus.level); end
        end
        @(negedge clock);
        bus.fifo_read = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.fifo_write !== 1'b0) begin errors++; $display("FAIL stall_read_cycle got rdy=%b w=%b exp 0000 0", bus.req_ready, bus.fifo_write); end
        @(negedge clock);
        bus.fifo_read = 1'b0;
        #1;
        checks++; if (bus.level !== 4'd7 || bus.busy !== 1'b0) begin errors++; $display("FAIL stall_after_read got lvl=%0d busy=%b exp 7 0", bus.level, bus.busy); end
        @(negedge clock); #1;
        checks++; if (bus.grant_id !== 2'd2 || bus.req_ready !== 4'b0100 || bus.fifo_write !== 1'b1 || bus.fifo_data !== 16'hB002) begin errors++; $display("FAIL stall_owner2 got id=%0d rdy=%b w=%b d=%h exp 2 0100 1 b002", bus.grant_id, bus.req_ready, bus.fifo_write, bus.fifo_data); end
        @(negedge clock); #1;
        checks++; if (bus.level !== 4'd8 || bus.req_ready !== 4'b0000 || bus.busy !== 1'b1) begin errors++; $display("FAIL stall_hold got lvl=%0d rdy=%b busy=%b exp 8 0000 1", bus.level, bus.req_ready, bus.busy); end
    endtask

    task automatic test_read_at_full();
        @(negedge clock);
        bus.fifo_read = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.level !== 4'd8) begin errors++; $display("FAIL full_read got rdy=%b w=%b lvl=%0d exp 0000 0 8", bus.req_ready, bus.fifo_write, bus.level); end
        @(negedge clock);
        bus.fifo_read = 1'b0;
        #1;
        checks++; if (bus.level !== 4'd7 || bus.req_ready !== 4'b0100 || bus.fifo_write !== 1'b1) begin errors++; $display("FAIL full_next got lvl=%0d rdy=%b w=%b exp 7 0100 1", bus.level, bus.req_ready, bus.fifo_write); end
        @(negedge clock); #1;
        checks++; if (bus.level !== 4'd8) begin errors++; $display("FAIL full_refill got lvl=%0d exp 8", bus.level); end
    endtask

    task automatic test_valid_drop_and_flush();
        do_reset();
        bus.req_valid = 4'b0100;
        bus.req_data[0 +: 16]  = 16'hC000;
        bus.req_data[32 +: 16] = 16'hC002;
        bus.req_data[48 +: 16] = 16'hC003;
        #1;
        for (int b = 0; b < 2; b++) begin
            @(negedge clock); #1;
            checks++; if (bus.grant_id !== 2'd2 || bus.fifo_write !== 1'b1 || bus.fifo_data !== 16'hC002) begin errors++; $display("FAIL drop_beat %0d got id=%0d w=%b d=%h exp 2 1 c002", b, bus.grant_id, bus.fifo_write, bus.fifo_data); end
        end
        @(negedge clock);
        bus.req_valid = 4'b1001;
        #1;
        checks++; if (bus.fifo_write !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL drop_cycle got w=%b busy=%b exp 0 1", bus.fifo_write, bus.busy); end
        @(negedge clock); #1;
        checks++; if (bus.busy !== 1'b0 || bus.level !== 4'd2) begin errors++; $display("FAIL drop_idle got busy=%b lvl=%0d exp 0 2", bus.busy, bus.level); end
        for (int b = 0; b < 3; b++) begin
            @(negedge clock); #1;
            checks++; if (bus.grant_id !== 2'd3 || bus.req_ready !== 4'b1000 || bus.fifo_data !== 16'hC003 || bus.level !== 4'(2 + b)) begin errors++; $display("FAIL rr_after2 beat %0d got id=%0d rdy=%b d=%h lvl=%0d exp 3 1000 c003 %0d", b, bus.grant_id, bus.req_ready, bus.fifo_data, bus.level, 2 + b); end
        end
        @(negedge clock);
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.fifo_write !== 1'b0 || bus.level !== 4'd5) begin errors++; $display("FAIL flush_cycle got rdy=%b w=%b lvl=%0d exp 0000 0 5", bus.req_ready, bus.fifo_write, bus.level); end
        @(negedge clock);
        bus.flush = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.fifo_clear !== 1'b1 || bus.fifo_write !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_clear got c=%b w=%b busy=%b exp 1 0 0", bus.fifo_clear, bus.fifo_write, bus.busy); end
        @(negedge clock); #1;
        checks++; if (bus.level !== 4'd0 || bus.fifo_clear !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL flush_done got lvl=%0d c=%b busy=%b exp 0 0 0", bus.level, bus.fifo_clear, bus.busy); end
    endtask

    task automatic test_read_empty_and_concurrent();
        do_reset();
        bus.fifo_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); #1;
            checks++; if (bus.level !== 4'd0) begin errors++; $display("FAIL empty_read %0d got lvl=%0d exp 0", k, bus.level); end
        end
        bus.fifo_read = 1'b0;
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 16] = 16'hD000;
        for (int b = 0; b < 3; b++) begin
            @(negedge clock); #1;
            checks++; if (bus.fifo_write !== 1'b1 || bus.level !== 4'(b)) begin errors++; $display("FAIL fill3 beat %0d got w=%b lvl=%0d exp 1 %0d", b, bus.fifo_write, bus.level, b); end
        end
        @(negedge clock);
        bus.req_valid = 4'b0000;
        #1;
        @(negedge clock);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.level !== 4'd3) begin errors++; $display("FAIL fill3_idle got busy=%b lvl=%0d exp 0 3", bus.busy, bus.level); end
        @(negedge clock);
        bus.fifo_read = 1'b1;
        #1;
        checks++; if (bus.fifo_write !== 1'b1) begin errors++; $display("FAIL wr_rd_write got w=%b exp 1", bus.fifo_write); end
        @(negedge clock);
        bus.fifo_read = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.level !== 4'd3) begin errors++; $display("FAIL wr_rd_level got lvl=%0d exp 3", bus.level); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_data[0 +: 16] = 16'hE000;
        @(negedge clock); #1;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++; if (bus.fifo_write !== 1'b1 || bus.level !== 4'd1) begin errors++; $display("FAIL rst_mid_pre got w=%b lvl=%0d exp 1 1", bus.fifo_write, bus.level); end
        @(negedge clock);
        reset = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.level !== 4'd0 || bus.busy !== 1'b0 || bus.grant_id !== 2'd0) begin errors++; $display("FAIL rst_mid_post got lvl=%0d busy=%b id=%0d exp 0 0 0", bus.level, bus.busy, bus.grant_id); end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_single_burst();
        test_full_stall();
        test_read_at_full();
        test_valid_drop_and_flush();
        test_read_empty_and_concurrent();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
